collatz_steps: RTL and testbench

//   Responder (sink) side of the sync valid/ready interface. Accepts one N-bit

---
 rtl/collatz_steps_if.sv | 23 ++
 rtl/collatz_steps.sv | 99 +++++++++
 tb/tb_collatz_steps.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/collatz_steps_if.sv
// Sync valid/ready bundle for the collatz cores.
// The producer/consumer side uses master; the responder block uses slave.
interface collatz_steps_if #(
  parameter int N = 27
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in0;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out0;
  logic         out1;

  modport master (
    output in_valid, in0, out_ready,
    input  in_ready, out_valid, out0, out1
  );

  modport slave (
    input  in_valid, in0, out_ready,
    output in_ready, out_valid, out0, out1
  );
endinterface

// File: rtl/collatz_steps.sv
// Collatz step counter responder: accepts one start value, iterates one step
// per cycle, and presents the step count (or overflow) on the result channel.
module collatz_steps #(
  parameter int N = 27
) (
  input  logic           clk,
  input  logic           nrst,
  collatz_steps_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e       state_q, state_d;
  logic [N-1:0] x_q, x_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] out0_q, out0_d;
  logic         out1_q, out1_d;
  logic         ovld_q, ovld_d;

  logic [N+1:0] t;
  logic [N-1:0] cnt_inc;

  // 3x+1 at two extra bits so the overflow into bits N+1:N is visible
  assign t       = ({2'b00, x_q} << 1) + {2'b00, x_q} + (N+2)'(1);
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + N'(1);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    out0_d  = out0_q;
    out1_d  = out1_q;
    ovld_d  = ovld_q;
    case (state_q)
      IDLE: begin
        ovld_d = 1'b0;
        if (bus.in_valid) begin
          x_d     = bus.in0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (x_q <= N'(1)) begin
          out0_d  = cnt_q;
          out1_d  = 1'b0;
          state_d = DONE;
        end else if (!x_q[0]) begin
          x_d   = x_q >> 1;
          cnt_d = cnt_inc;
        end else if (|t[N+1:N]) begin
          out0_d  = cnt_q;
          out1_d  = 1'b1;
          state_d = DONE;
        end else begin
          x_d   = t[N-1:0];
          cnt_d = cnt_inc;
        end
      end
      DONE: begin
        // result is presented one cycle after entering DONE
        if (ovld_q && bus.out_ready) begin
          ovld_d  = 1'b0;
          state_d = IDLE;
        end else begin
          ovld_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ovld_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      x_q     <= '0;
      cnt_q   <= '0;
      out0_q  <= '0;
      out1_q  <= 1'b0;
      ovld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      out0_q  <= out0_d;
      out1_q  <= out1_d;
      ovld_q  <= ovld_d;
    end
  end

  assign bus.in_ready  = nrst && (state_q == IDLE);
  assign bus.out_valid = ovld_q;
  assign bus.out0      = out0_q;
  assign bus.out1      = out1_q;

endmodule

// File: tb/tb_collatz_steps.sv
// Directed bench for collatz_steps: hand-computed step counts and latencies.
module tb_collatz_steps;
  localparam int N = 27;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  collatz_steps_if #(.N(N)) bus ();

  collatz_steps #(.N(N)) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Accept v, keep poking in_valid with junk while busy, check result and latency.
  task automatic run_txn(input logic [N-1:0] v, input logic [N-1:0] e0,
                         input logic e1, input int elat, input string nm);
    int   lat;
    logic rdy_seen;
    n_chk++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s in_ready before accept: got %b want 1", nm, bus.in_ready);
    end
    bus.in0 = v; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    step;
    lat = 0; rdy_seen = 1'b0;
    while (bus.out_valid !== 1'b1 && lat < 400) begin
      if (bus.in_ready !== 1'b0) rdy_seen = 1'b1;
      bus.in0 = N'($urandom);
      step;
      lat++;
    end
    bus.in_valid = 1'b0;
    n_chk++;
    if (rdy_seen) begin
      n_fail++;
      $display("FAIL %s in_ready while busy: got 1 want 0", nm);
    end
    n_chk++;
    if (lat != elat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d", nm, lat, elat);
    end
    n_chk++;
    if (bus.out0 !== e0) begin
      n_fail++;
      $display("FAIL %s out0: got %0d want %0d", nm, bus.out0, e0);
    end
    n_chk++;
    if (bus.out1 !== e1) begin
      n_fail++;
      $display("FAIL %s out1: got %b want %b", nm, bus.out1, e1);
    end
    step;
    n_chk++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s after handshake: got out_valid=%b in_ready=%b want 0/1",
               nm, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset;
    bus.in_valid = 1'b0; bus.in0 = '0; bus.out_ready = 1'b0;
    nrst = 1'b0;
    step; step;
    n_chk++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 ||
        bus.out0 !== '0 || bus.out1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b vld=%b out0=%0d out1=%b want 0/0/0/0",
               bus.in_ready, bus.out_valid, bus.out0, bus.out1);
    end
    nrst = 1'b1;
    #1;
    n_chk++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release in_ready: got %b want 1", bus.in_ready);
    end
    // out_ready with nothing to present must be harmless
    bus.out_ready = 1'b1;
    step; step;
    n_chk++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_out_ready: got vld=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_basic;
    run_txn(N'(27), N'(111), 1'b0, 113, "basic27");
  endtask

  task automatic test_small;
    run_txn(N'(1), N'(0), 1'b0, 2, "one");
    run_txn(N'(0), N'(0), 1'b0, 2, "zero");
  endtask

  task automatic test_back_to_back;
    run_txn(N'(6), N'(8), 1'b0, 10, "b2b6");
    run_txn(N'(7), N'(16), 1'b0, 18, "b2b7");
  endtask

  task automatic test_overflow;
    logic [N-1:0] big;
    big = '1;
    run_txn(big, N'(0), 1'b1, 2, "ovf");
  endtask

  task automatic test_hold;
    int n;
    bus.in0 = N'(27); bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    step;
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 400) begin
      step;
      n++;
    end
    n_chk++;
    if (n != 113) begin
      n_fail++;
      $display("FAIL hold latency: got %0d want 113", n);
    end
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (bus.out_valid !== 1'b1 || bus.out0 !== N'(111) || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold cycle %0d: got vld=%b out0=%0d rdy=%b want 1/111/0",
                 i, bus.out_valid, bus.out0, bus.in_ready);
      end
      step;
    end
    n_chk++;
    if (bus.out_valid !== 1'b1 || bus.out0 !== N'(111)) begin
      n_fail++;
      $display("FAIL hold before release: got vld=%b out0=%0d want 1/111",
               bus.out_valid, bus.out0);
    end
    bus.out_ready = 1'b1;
    step;
    n_chk++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out0 !== N'(111)) begin
      n_fail++;
      $display("FAIL hold release: got vld=%b rdy=%b out0=%0d want 0/1/111",
               bus.out_valid, bus.in_ready, bus.out0);
    end
  endtask

  task automatic test_reset_mid_run;
    logic vld_seen;
    bus.in0 = N'(27); bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    step;
    bus.in_valid = 1'b0;
    repeat (20) step;
    nrst = 1'b0;
    step;
    nrst = 1'b1;
    #1;
    n_chk++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out0 !== '0) begin
      n_fail++;
      $display("FAIL abort state: got rdy=%b vld=%b out0=%0d want 1/0/0",
               bus.in_ready, bus.out_valid, bus.out0);
    end
    vld_seen = 1'b0;
    repeat (120) begin
      step;
      if (bus.out_valid !== 1'b0) vld_seen = 1'b1;
    end
    n_chk++;
    if (vld_seen) begin
      n_fail++;
      $display("FAIL abort result leaked: got out_valid=1 want 0");
    end
    run_txn(N'(3), N'(7), 1'b0, 9, "after_abort3");
  endtask

  initial begin
    test_reset;
    test_basic;
    test_small;
    test_back_to_back;
    test_overflow;
    test_hold;
    test_reset_mid_run;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
